// File: rtl/tow_pkg.sv
// Shared types for the tug-of-war match controller: phase and winner encodings,
// score width and a saturating score increment.
package tow_pkg;

    localparam int unsigned SCORE_W = 3;

    typedef enum logic [2:0] {
        CLEAR     = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        OVER      = 3'd4
    } phase_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } winner_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] lim);
        return (s >= lim) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by the countdown and point-hold phases.
// Holds at zero; done is high whenever the count is zero.
module phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/tow_match_ctrl.sv
// Tug-of-war match controller: round sequencing, press arbitration,
// point detection, score keeping and winner declaration.
module tow_match_ctrl
    import tow_pkg::*;
#(
    parameter int unsigned COUNT_CYCLES = 50_000_000,
    parameter int unsigned POINT_CYCLES = 100_000_000,
    parameter int unsigned WIN_SCORE    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               l_press,
    input  logic               r_press,
    input  logic               left_end,
    input  logic               right_end,
    output logic               field_reset,
    output logic               l_move,
    output logic               r_move,
    output logic [SCORE_W-1:0] l_score,
    output logic [SCORE_W-1:0] r_score,
    output logic [2:0]         phase,
    output logic [1:0]         winner
);

    localparam int unsigned MAX_CYCLES = (COUNT_CYCLES > POINT_CYCLES) ? COUNT_CYCLES : POINT_CYCLES;
    localparam int unsigned TW         = $clog2(MAX_CYCLES);
    localparam logic [TW-1:0] COUNT_LOAD = TW'(COUNT_CYCLES - 1);
    localparam logic [TW-1:0] POINT_LOAD = TW'(POINT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);

    phase_t             state, state_nx;
    winner_t            win_q, win_nx;
    logic               field_reset_nx, l_move_nx, r_move_nx;
    logic [SCORE_W-1:0] l_score_nx, r_score_nx;
    logic               tmr_load, tmr_done;
    logic [TW-1:0]      tmr_value;
    logic               l_only, r_only, both;

    assign l_only = l_press & ~r_press;
    assign r_only = r_press & ~l_press;
    assign both   = l_press & r_press;

    phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

    always_comb begin
        state_nx   = state;
        win_nx     = win_q;
        l_move_nx  = 1'b0;
        r_move_nx  = 1'b0;
        l_score_nx = l_score;
        r_score_nx = r_score;
        tmr_load   = 1'b0;
        tmr_value  = COUNT_LOAD;

        case (state)
            CLEAR: begin
                tmr_load = 1'b1;
                state_nx = COUNTDOWN;
            end
            // a press on the final countdown cycle still counts as a false start
            COUNTDOWN: begin
                if (both) begin
                    tmr_load = 1'b1;
                end else if (l_only) begin
                    r_score_nx = sat_inc(r_score, WIN);
                    tmr_load   = 1'b1;
                    tmr_value  = POINT_LOAD;
                    state_nx   = POINT;
                end else if (r_only) begin
                    l_score_nx = sat_inc(l_score, WIN);
                    tmr_load   = 1'b1;
                    tmr_value  = POINT_LOAD;
                    state_nx   = POINT;
                end else if (tmr_done) begin
                    state_nx = PLAY;
                end
            end
            PLAY: begin
                if (l_only) begin
                    if (left_end) begin
                        l_score_nx = sat_inc(l_score, WIN);
                        tmr_load   = 1'b1;
                        tmr_value  = POINT_LOAD;
                        state_nx   = POINT;
                    end else begin
                        l_move_nx = 1'b1;
                    end
                end else if (r_only) begin
                    if (right_end) begin
                        r_score_nx = sat_inc(r_score, WIN);
                        tmr_load   = 1'b1;
                        tmr_value  = POINT_LOAD;
                        state_nx   = POINT;
                    end else begin
                        r_move_nx = 1'b1;
                    end
                end
            end
            POINT: begin
                if (tmr_done) begin
                    if (l_score == WIN) begin
                        state_nx = OVER;
                        win_nx   = LEFT;
                    end else if (r_score == WIN) begin
                        state_nx = OVER;
                        win_nx   = RIGHT;
                    end else begin
                        state_nx = CLEAR;
                    end
                end
            end
            OVER: begin
                state_nx = OVER;
            end
            default: begin
                state_nx = CLEAR;
            end
        endcase

        field_reset_nx = (state_nx == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CLEAR;
            win_q       <= NONE;
            field_reset <= 1'b1;
            l_move      <= 1'b0;
            r_move      <= 1'b0;
            l_score     <= '0;
            r_score     <= '0;
        end else begin
            state       <= state_nx;
            win_q       <= win_nx;
            field_reset <= field_reset_nx;
            l_move      <= l_move_nx;
            r_move      <= r_move_nx;
            l_score     <= l_score_nx;
            r_score     <= r_score_nx;
        end
    end

    assign phase  = state;
    assign winner = win_q;

endmodule
